// File: rtl/rf_access_client.sv
// Issue-side client for the bypass register file: reserves read slots, allocates write names,
// captures operands, and frees write names in order. Optional stall counters under RF_CLIENT_PERF_EN.
module rf_access_client #(
  parameter int unsigned addr_width = 5,
  parameter int unsigned data_width = 32,
  parameter int unsigned name_width = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [addr_width-1:0] REQ_RS1,
  input  logic [addr_width-1:0] REQ_RS2,
  input  logic [addr_width-1:0] REQ_RD,
  input  logic                  REQ_WEN,
  output logic                  OP_VALID,
  input  logic                  OP_READY,
  output logic [data_width-1:0] OP_A,
  output logic [data_width-1:0] OP_B,
  output logic [name_width-1:0] OP_WNAME,
  output logic                  OP_WEN,
  input  logic                  WB_VALID,
  input  logic [name_width-1:0] WB_NAME,
  input  logic [data_width-1:0] WB_DATA,
  output logic                  WB_ERR,
  output logic [addr_width-1:0] RF_ADDR_IN,
  output logic [addr_width-1:0] RF_ADDR_1,
  output logic [addr_width-1:0] RF_ADDR_2,
  output logic                  RF_ALLOC_E,
  output logic                  RF_RRESE_1,
  output logic                  RF_RRESE_2,
  input  logic                  RF_ALLOC_READY,
  input  logic                  RF_RRES_READY_1,
  input  logic                  RF_RRES_READY_2,
  input  logic [name_width-1:0] RF_NAME_OUT,
  input  logic [name_width-1:0] RF_RNAME_OUT_1,
  input  logic [name_width-1:0] RF_RNAME_OUT_2,
  output logic [name_width-1:0] RF_VALID_NAME_1,
  output logic [name_width-1:0] RF_VALID_NAME_2,
  input  logic                  RF_VALID_OUT_1,
  input  logic                  RF_VALID_OUT_2,
  output logic [name_width-1:0] RF_NAME_1,
  output logic [name_width-1:0] RF_NAME_2,
  input  logic [data_width-1:0] RF_D_OUT_1,
  input  logic [data_width-1:0] RF_D_OUT_2,
  output logic                  RF_FE_1,
  output logic                  RF_FE_2,
  output logic [name_width-1:0] RF_RD_F_1,
  output logic [name_width-1:0] RF_RD_F_2,
  output logic                  RF_WE_1,
  output logic [name_width-1:0] RF_NAME_IN_1,
  output logic [data_width-1:0] RF_D_IN_1,
  output logic                  RF_WFE,
  output logic [name_width-1:0] RF_W_F,
  input  logic                  RF_F_READY,
  output logic [31:0]           PERF_RES_STALL,
  output logic [31:0]           PERF_WAIT_STALL
);

  localparam int unsigned DEPTH = 1 << name_width;
  localparam int unsigned CNT_W = name_width + 1;

  typedef enum logic [1:0] {S_IDLE, S_RES, S_WAIT, S_OUT} state_e;

  state_e                  state_q, state_d;
  logic [addr_width-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                    wen_q, wen_d;
  logic [name_width-1:0]   rname1_q, rname1_d, rname2_q, rname2_d, wname_q, wname_d;
  logic                    cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic [data_width-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic                    wb_err_q, wb_err_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [name_width-1:0]   head_q, head_d, tail_q, tail_d;
  logic [name_width-1:0]   fifo_q [DEPTH];
  logic [name_width-1:0]   fifo_d [DEPTH];
  logic [DEPTH-1:0]        outst_q, outst_d, written_q, written_d;

  logic go_c, qfull_c, push_c, pop_c, both_c, wfe_c;
  logic [name_width-1:0] head_name_c;

  assign qfull_c     = (count_q == CNT_W'(DEPTH));
  assign go_c        = RF_RRES_READY_1 & RF_RRES_READY_2 & (~wen_q | (RF_ALLOC_READY & ~qfull_c));
  assign both_c      = (cap_a_q | RF_VALID_OUT_1) & (cap_b_q | RF_VALID_OUT_2);
  assign head_name_c = fifo_q[head_q];
  assign wfe_c       = (count_q != '0) & written_q[head_name_c];
  assign push_c      = (state_q == S_RES) & go_c & wen_q;
  assign pop_c       = wfe_c & RF_F_READY;

  // Request sequencing: reserve, collect operands, hand off downstream.
  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    wen_d      = wen_q;
    rname1_d   = rname1_q;
    rname2_d   = rname2_q;
    wname_d    = wname_q;
    cap_a_d    = cap_a_q;
    cap_b_d    = cap_b_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    REQ_READY  = 1'b0;
    OP_VALID   = 1'b0;
    RF_RRESE_1 = 1'b0;
    RF_RRESE_2 = 1'b0;
    RF_ALLOC_E = 1'b0;
    RF_FE_1    = 1'b0;
    RF_FE_2    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          rs1_d   = REQ_RS1;
          rs2_d   = REQ_RS2;
          rd_d    = REQ_RD;
          wen_d   = REQ_WEN;
          state_d = S_RES;
        end
      end
      S_RES: begin
        if (go_c) begin
          RF_RRESE_1 = 1'b1;
          RF_RRESE_2 = 1'b1;
          RF_ALLOC_E = wen_q;
          rname1_d   = RF_RNAME_OUT_1;
          rname2_d   = RF_RNAME_OUT_2;
          if (wen_q) wname_d = RF_NAME_OUT;
          cap_a_d    = 1'b0;
          cap_b_d    = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!cap_a_q && RF_VALID_OUT_1) begin
          op_a_d  = RF_D_OUT_1;
          cap_a_d = 1'b1;
        end
        if (!cap_b_q && RF_VALID_OUT_2) begin
          op_b_d  = RF_D_OUT_2;
          cap_b_d = 1'b1;
        end
        if (both_c) begin
          RF_FE_1 = 1'b1;
          RF_FE_2 = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        OP_VALID = 1'b1;
        if (OP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writeback tracking and in-order free queue; push, pop and writeback are independent.
  always_comb begin
    outst_d   = outst_q;
    written_d = written_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    fifo_d    = fifo_q;
    wb_err_d  = wb_err_q;
    if (RF_WE_1) written_d[WB_NAME] = 1'b1;
    if (WB_VALID && !outst_q[WB_NAME]) wb_err_d = 1'b1;
    if (pop_c) begin
      outst_d[head_name_c]   = 1'b0;
      written_d[head_name_c] = 1'b0;
      head_d                 = head_q + name_width'(1);
    end
    if (push_c) begin
      outst_d[RF_NAME_OUT]   = 1'b1;
      written_d[RF_NAME_OUT] = 1'b0;
      fifo_d[tail_q]         = RF_NAME_OUT;
      tail_d                 = tail_q + name_width'(1);
    end
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      rname1_q  <= '0;
      rname2_q  <= '0;
      wname_q   <= '0;
      cap_a_q   <= 1'b0;
      cap_b_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      wb_err_q  <= 1'b0;
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      outst_q   <= '0;
      written_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      rname1_q  <= rname1_d;
      rname2_q  <= rname2_d;
      wname_q   <= wname_d;
      cap_a_q   <= cap_a_d;
      cap_b_q   <= cap_b_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      wb_err_q  <= wb_err_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      outst_q   <= outst_d;
      written_q <= written_d;
      fifo_q    <= fifo_d;
    end
  end

  assign OP_A            = op_a_q;
  assign OP_B            = op_b_q;
  assign OP_WNAME        = wname_q;
  assign OP_WEN          = wen_q;
  assign WB_ERR          = wb_err_q;
  assign RF_ADDR_IN      = rd_q;
  assign RF_ADDR_1       = rs1_q;
  assign RF_ADDR_2       = rs2_q;
  assign RF_VALID_NAME_1 = rname1_q;
  assign RF_VALID_NAME_2 = rname2_q;
  assign RF_NAME_1       = rname1_q;
  assign RF_NAME_2       = rname2_q;
  assign RF_RD_F_1       = rname1_q;
  assign RF_RD_F_2       = rname2_q;
  assign RF_WE_1         = WB_VALID & outst_q[WB_NAME];
  assign RF_NAME_IN_1    = WB_NAME;
  assign RF_D_IN_1       = WB_DATA;
  assign RF_WFE          = wfe_c;
  assign RF_W_F          = head_name_c;

`ifdef RF_CLIENT_PERF_EN
  logic [31:0] res_stall_q, wait_stall_q;

  // Saturating stall counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_stall_q  <= '0;
      wait_stall_q <= '0;
    end else begin
      if ((state_q == S_RES) && !go_c && (res_stall_q != '1))
        res_stall_q <= res_stall_q + 32'd1;
      if ((state_q == S_WAIT) && !both_c && (wait_stall_q != '1))
        wait_stall_q <= wait_stall_q + 32'd1;
    end
  end

  assign PERF_RES_STALL  = res_stall_q;
  assign PERF_WAIT_STALL = wait_stall_q;
`else
  assign PERF_RES_STALL  = '0;
  assign PERF_WAIT_STALL = '0;
`endif

endmodule

// File: tb/tb_rf_access_client.sv
// Directed bench for rf_access_client: reservation, operand capture, in-order write free,
// queue-full stall and writeback error.
module tb_rf_access_client;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID, REQ_READY, REQ_WEN;
  logic [4:0]  REQ_RS1, REQ_RS2, REQ_RD;
  logic        OP_VALID, OP_READY, OP_WEN;
  logic [31:0] OP_A, OP_B;
  logic [1:0]  OP_WNAME;
  logic        WB_VALID, WB_ERR;
  logic [1:0]  WB_NAME;
  logic [31:0] WB_DATA;
  logic [4:0]  RF_ADDR_IN, RF_ADDR_1, RF_ADDR_2;
  logic        RF_ALLOC_E, RF_RRESE_1, RF_RRESE_2;
  logic        RF_ALLOC_READY, RF_RRES_READY_1, RF_RRES_READY_2;
  logic [1:0]  RF_NAME_OUT, RF_RNAME_OUT_1, RF_RNAME_OUT_2;
  logic [1:0]  RF_VALID_NAME_1, RF_VALID_NAME_2;
  logic        RF_VALID_OUT_1, RF_VALID_OUT_2;
  logic [1:0]  RF_NAME_1, RF_NAME_2;
  logic [31:0] RF_D_OUT_1, RF_D_OUT_2;
  logic        RF_FE_1, RF_FE_2;
  logic [1:0]  RF_RD_F_1, RF_RD_F_2;
  logic        RF_WE_1;
  logic [1:0]  RF_NAME_IN_1;
  logic [31:0] RF_D_IN_1;
  logic        RF_WFE;
  logic [1:0]  RF_W_F;
  logic        RF_F_READY;
  logic [31:0] PERF_RES_STALL, PERF_WAIT_STALL;

  int n_vec = 0;
  int n_bad = 0;

`ifdef RF_CLIENT_PERF_EN
  localparam logic [31:0] EXP_RES_STALL  = 32'd4;
  localparam logic [31:0] EXP_WAIT_STALL = 32'd2;
`else
  localparam logic [31:0] EXP_RES_STALL  = 32'd0;
  localparam logic [31:0] EXP_WAIT_STALL = 32'd0;
`endif

  rf_access_client dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2), .REQ_RD(REQ_RD), .REQ_WEN(REQ_WEN),
    .OP_VALID(OP_VALID), .OP_READY(OP_READY), .OP_A(OP_A), .OP_B(OP_B),
    .OP_WNAME(OP_WNAME), .OP_WEN(OP_WEN),
    .WB_VALID(WB_VALID), .WB_NAME(WB_NAME), .WB_DATA(WB_DATA), .WB_ERR(WB_ERR),
    .RF_ADDR_IN(RF_ADDR_IN), .RF_ADDR_1(RF_ADDR_1), .RF_ADDR_2(RF_ADDR_2),
    .RF_ALLOC_E(RF_ALLOC_E), .RF_RRESE_1(RF_RRESE_1), .RF_RRESE_2(RF_RRESE_2),
    .RF_ALLOC_READY(RF_ALLOC_READY), .RF_RRES_READY_1(RF_RRES_READY_1),
    .RF_RRES_READY_2(RF_RRES_READY_2),
    .RF_NAME_OUT(RF_NAME_OUT), .RF_RNAME_OUT_1(RF_RNAME_OUT_1), .RF_RNAME_OUT_2(RF_RNAME_OUT_2),
    .RF_VALID_NAME_1(RF_VALID_NAME_1), .RF_VALID_NAME_2(RF_VALID_NAME_2),
    .RF_VALID_OUT_1(RF_VALID_OUT_1), .RF_VALID_OUT_2(RF_VALID_OUT_2),
    .RF_NAME_1(RF_NAME_1), .RF_NAME_2(RF_NAME_2),
    .RF_D_OUT_1(RF_D_OUT_1), .RF_D_OUT_2(RF_D_OUT_2),
    .RF_FE_1(RF_FE_1), .RF_FE_2(RF_FE_2), .RF_RD_F_1(RF_RD_F_1), .RF_RD_F_2(RF_RD_F_2),
    .RF_WE_1(RF_WE_1), .RF_NAME_IN_1(RF_NAME_IN_1), .RF_D_IN_1(RF_D_IN_1),
    .RF_WFE(RF_WFE), .RF_W_F(RF_W_F), .RF_F_READY(RF_F_READY),
    .PERF_RES_STALL(PERF_RES_STALL), .PERF_WAIT_STALL(PERF_WAIT_STALL)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven just after the falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Full request with both operands already valid; checks the granted write name.
  task automatic run_req(input logic [4:0] rd, input logic wen, input logic [1:0] name);
    RF_VALID_OUT_1 = 1'b1;
    RF_VALID_OUT_2 = 1'b1;
    REQ_RS1 = 5'd1; REQ_RS2 = 5'd2; REQ_RD = rd; REQ_WEN = wen;
    RF_NAME_OUT = name;
    REQ_VALID = 1'b1;
    step();
    REQ_VALID = 1'b0;
    #1 check_eq("run_req_rrese", 32'(RF_RRESE_1), 32'd1);
    step();
    step();
    #1 check_eq("run_req_wname", 32'(OP_WNAME), 32'(name));
    OP_READY = 1'b1;
    step();
    OP_READY = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    REQ_VALID = 0; REQ_RS1 = 0; REQ_RS2 = 0; REQ_RD = 0; REQ_WEN = 0;
    OP_READY = 0; WB_VALID = 0; WB_NAME = 0; WB_DATA = 0;
    RF_ALLOC_READY = 1; RF_RRES_READY_1 = 1; RF_RRES_READY_2 = 1;
    RF_NAME_OUT = 0; RF_RNAME_OUT_1 = 2'd1; RF_RNAME_OUT_2 = 2'd2;
    RF_VALID_OUT_1 = 0; RF_VALID_OUT_2 = 0; RF_D_OUT_1 = 0; RF_D_OUT_2 = 0;
    RF_F_READY = 0;
    step();
    step();
    RST = 1'b0;
    #1;
    check_eq("rst_req_ready", 32'(REQ_READY), 32'd1);
    check_eq("rst_op_valid", 32'(OP_VALID), 32'd0);
    check_eq("rst_wb_err", 32'(WB_ERR), 32'd0);
    check_eq("rst_wfe", 32'(RF_WFE), 32'd0);

    // Basic request: rs1=3, rs2=4, rd=5, wen=1.
    RF_VALID_OUT_1 = 1; RF_D_OUT_1 = 32'h11;
    RF_VALID_OUT_2 = 1; RF_D_OUT_2 = 32'h22;
    REQ_RS1 = 5'd3; REQ_RS2 = 5'd4; REQ_RD = 5'd5; REQ_WEN = 1; REQ_VALID = 1;
    step();
    REQ_VALID = 0;
    #1;
    check_eq("t1_rrese", {29'd0, RF_ALLOC_E, RF_RRESE_2, RF_RRESE_1}, 32'h7);
    check_eq("t1_addrs", {17'd0, RF_ADDR_IN, RF_ADDR_2, RF_ADDR_1}, {17'd0, 5'd5, 5'd4, 5'd3});
    check_eq("t1_req_ready", 32'(REQ_READY), 32'd0);
    step();
    #1;
    check_eq("t1_fe", {30'd0, RF_FE_2, RF_FE_1}, 32'h3);
    check_eq("t1_rd_f", {28'd0, RF_RD_F_2, RF_RD_F_1}, {28'd0, 2'd2, 2'd1});
    check_eq("t1_valid_name", {28'd0, RF_VALID_NAME_2, RF_VALID_NAME_1}, {28'd0, 2'd2, 2'd1});
    check_eq("t1_op_valid_early", 32'(OP_VALID), 32'd0);
    step();
    #1;
    check_eq("t1_op_valid", 32'(OP_VALID), 32'd1);
    check_eq("t1_op_a", OP_A, 32'h11);
    check_eq("t1_op_b", OP_B, 32'h22);
    check_eq("t1_wname_wen", {29'd0, OP_WEN, OP_WNAME}, 32'h4);
    check_eq("t1_fe_once", {30'd0, RF_FE_2, RF_FE_1}, 32'h0);
    OP_READY = 1;
    step();
    OP_READY = 0;
    #1 check_eq("t1_back_idle", 32'(REQ_READY), 32'd1);

    // Reservation stall for four cycles, then staggered operand arrival.
    RF_RRES_READY_2 = 0;
    RF_VALID_OUT_1 = 0; RF_VALID_OUT_2 = 0;
    REQ_RS1 = 5'd6; REQ_RS2 = 5'd7; REQ_RD = 5'd8; REQ_WEN = 0; REQ_VALID = 1;
    step();
    REQ_VALID = 0;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("t2_stall_en", {29'd0, RF_ALLOC_E, RF_RRESE_2, RF_RRESE_1}, 32'h0);
      step();
    end
    RF_RRES_READY_2 = 1;
    #1 check_eq("t2_res_go", {29'd0, RF_ALLOC_E, RF_RRESE_2, RF_RRESE_1}, 32'h3);
    check_eq("t2_perf_res", PERF_RES_STALL, EXP_RES_STALL);
    step();
    RF_VALID_OUT_1 = 1; RF_D_OUT_1 = 32'hA1;
    #1 check_eq("t3_fe_wait1", 32'(RF_FE_1), 32'd0);
    step();
    RF_D_OUT_1 = 32'hBAD;
    #1 check_eq("t3_fe_wait2", 32'(RF_FE_1), 32'd0);
    step();
    RF_VALID_OUT_2 = 1; RF_D_OUT_2 = 32'hB2; RF_D_OUT_1 = 32'hCC;
    #1 check_eq("t3_fe_b", {30'd0, RF_FE_2, RF_FE_1}, 32'h3);
    step();
    #1;
    check_eq("t3_op_a", OP_A, 32'hA1);
    check_eq("t3_op_b", OP_B, 32'hB2);
    check_eq("t3_op_wen", 32'(OP_WEN), 32'd0);
    check_eq("t3_perf_wait", PERF_WAIT_STALL, EXP_WAIT_STALL);
    RF_D_OUT_1 = 32'hDEAD;
    step();
    #1 check_eq("t3_op_a_hold", OP_A, 32'hA1);
    OP_READY = 1;
    step();
    OP_READY = 0;

    // Names 0 and 1 outstanding; written out of order, freed in order.
    run_req(5'd9, 1'b1, 2'd1);
    WB_VALID = 1; WB_NAME = 2'd1; WB_DATA = 32'h55;
    #1 check_eq("t4_we_n1", {27'd0, RF_WE_1, 2'd0, RF_NAME_IN_1}, 32'h11);
    check_eq("t4_d_in", RF_D_IN_1, 32'h55);
    step();
    RF_F_READY = 1;
    WB_NAME = 2'd0; WB_DATA = 32'h66;
    #1 check_eq("t4_no_wfe", 32'(RF_WFE), 32'd0);
    check_eq("t4_we_n0", 32'(RF_WE_1), 32'd1);
    step();
    WB_VALID = 0;
    #1 check_eq("t4_free0", {29'd0, RF_WFE, RF_W_F}, 32'h4);
    step();
    #1 check_eq("t4_free1", {29'd0, RF_WFE, RF_W_F}, 32'h5);
    step();
    #1 check_eq("t4_empty", 32'(RF_WFE), 32'd0);
    RF_F_READY = 0;

    // Fill the queue (positions 2,3,0,1), then a fifth write request stalls.
    run_req(5'd10, 1'b1, 2'd2);
    run_req(5'd11, 1'b1, 2'd3);
    run_req(5'd12, 1'b1, 2'd0);
    run_req(5'd13, 1'b1, 2'd1);
    REQ_RD = 5'd14; REQ_WEN = 1; RF_NAME_OUT = 2'd2; REQ_VALID = 1;
    step();
    REQ_VALID = 0;
    RF_F_READY = 1;
    WB_VALID = 1; WB_NAME = 2'd2; WB_DATA = 32'h77;
    #1 check_eq("t5_full_stall", {29'd0, RF_ALLOC_E, RF_RRESE_2, RF_RRESE_1}, 32'h0);
    step();
    WB_NAME = 2'd3;
    #1 check_eq("t5_free2", {29'd0, RF_WFE, RF_W_F}, 32'h6);
    check_eq("t5_still_full", 32'(RF_ALLOC_E), 32'd0);
    step();
    WB_VALID = 0;
    #1 check_eq("t5_res_go", {29'd0, RF_ALLOC_E, RF_RRESE_2, RF_RRESE_1}, 32'h7);
    check_eq("t5_addr_in", 32'(RF_ADDR_IN), 32'd14);
    check_eq("t5_free3", {29'd0, RF_WFE, RF_W_F}, 32'h7);
    step();
    #1 check_eq("t5_head_wrap", {29'd0, RF_WFE, RF_W_F}, 32'h0);
    step();
    #1 check_eq("t5_op_wname", {29'd0, OP_WEN, OP_WNAME}, 32'h6);
    check_eq("t5_op_valid", 32'(OP_VALID), 32'd1);
    OP_READY = 1;
    step();
    OP_READY = 0;
    RF_F_READY = 0;

    // Writeback to a name that is not outstanding.
    RST = 1;
    step();
    RST = 0;
    #1 check_eq("t6_rst_wfe", 32'(RF_WFE), 32'd0);
    WB_VALID = 1; WB_NAME = 2'd2; WB_DATA = 32'h99;
    #1 check_eq("t6_no_we", 32'(RF_WE_1), 32'd0);
    step();
    WB_VALID = 0;
    #1 check_eq("t6_err_set", 32'(WB_ERR), 32'd1);
    step();
    #1 check_eq("t6_err_sticky", 32'(WB_ERR), 32'd1);
    RST = 1;
    step();
    RST = 0;
    #1 check_eq("t6_err_clear", 32'(WB_ERR), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_access_client.md
Name: rf_access_client

Overview:
- Initiator-side adapter for the bypass register file's reservation protocol.
- Sits between issue and execute, one per pipeline.
- Per request, it reserves both RF read slots and (optionally) allocates a write name, then polls and captures operand data, releases the read slots, and hands the operands downstream.
- It drives writeback data into the RF and frees write names strictly in allocation order.

Parameters:
- addr_width, 5, architectural register index width; must match the RF.
- data_width, 32, register data width.
- name_width, 2, RF write-name width; the outstanding-write queue depth is 2**name_width.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- REQ_VALID/REQ_READY  in/out  1  request handshake
- REQ_RS1, REQ_RS2, REQ_RD  in  addr_width  source and destination registers
- REQ_WEN  in  1  request writes REQ_RD
- OP_VALID/OP_READY  out/in  1  operand handshake
- OP_A, OP_B  out  data_width  captured operands
- OP_WNAME  out  name_width  allocated write name
- OP_WEN  out  1  copy of REQ_WEN
- WB_VALID  in  1  writeback strobe
- WB_NAME  in  name_width  writeback name
- WB_DATA  in  data_width  writeback data
- WB_ERR  out  1  sticky: writeback to a name that is not outstanding
- RF_ADDR_IN, RF_ADDR_1, RF_ADDR_2  out  addr_width  reservation addresses
- RF_ALLOC_E, RF_RRESE_1, RF_RRESE_2  out  1  reservation enables
- RF_ALLOC_READY, RF_RRES_READY_1, RF_RRES_READY_2  in  1  reservation readies
- RF_NAME_OUT, RF_RNAME_OUT_1, RF_RNAME_OUT_2  in  name_width  granted names
- RF_VALID_NAME_1/2  out  name_width; RF_VALID_OUT_1/2  in  1  validity poll
- RF_NAME_1/2  out  name_width; RF_D_OUT_1/2  in  data_width  data read
- RF_FE_1/2  out  1; RF_RD_F_1/2  out  name_width  read free
- RF_WE_1  out  1; RF_NAME_IN_1  out  name_width; RF_D_IN_1  out  data_width  write
- RF_WFE  out  1; RF_W_F  out  name_width; RF_F_READY  in  1  write free
- PERF_RES_STALL, PERF_WAIT_STALL  out  32  stall counters (see Optional Feature)

Behaviour:
- Reset values: FSM=IDLE; all enables, OP_VALID, WB_ERR, queue count/head/tail, and written bits = 0; REQ_READY=1.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, latch rs1/rs2/rd/wen, then go to RES.
- RES (all-or-nothing reservation):
  - go = RRES_READY_1 & RRES_READY_2 & (!wen | (ALLOC_READY & !qfull)).
  - When go=1: assert RRESE_1 and RRESE_2, plus ALLOC_E if wen, all in the same cycle.
  - Latch RNAME_OUT_1/2; latch NAME_OUT into OP_WNAME and push it at the queue tail.
  - Next state: WAIT.
  - When go=0: no enables asserted; stay in RES.
- WAIT:
  - VALID_NAME_x and NAME_x drive the latched read names.
  - Each operand is captured from D_OUT_x in the first cycle VALID_OUT_x=1; a per-operand captured bit prevents recapture.
  - In the cycle both operands are (or become) captured, assert FE_1 (RD_F_1=name1) and FE_2 (RD_F_2=name2), then go to OUT.
  - Minimum WAIT dwell is 1 cycle.
- OUT:
  - OP_VALID=1; outputs are stable until OP_READY.
  - On OP_READY, go to IDLE.
  - Minimum latency, request accept to OP_VALID, is 3 cycles.
- Writeback:
  - RF_WE_1 = WB_VALID & outstanding[WB_NAME]; name and data pass through combinationally.
  - The written bit for WB_NAME is set at the next edge.
  - WB_VALID to a name that is not outstanding: no WE, WB_ERR set sticky until reset.
- In-order write free:
  - WFE = count!=0 & written[head]; W_F = head name.
  - On WFE & F_READY: clear outstanding/written[head], advance head, decrement count.
  - The written bit is registered, so a free occurs no earlier than 1 cycle after writeback.
- Queue:
  - qfull when count == 2**name_width.
  - Head and tail wrap modulo depth.
  - Push and pop in the same cycle leave count unchanged.
- Simultaneous events: a writeback, a free and a reservation in one cycle are all honoured independently.
- Reset mid-operation: all state is discarded; the RF must be reset in the same cycle.

Optional Feature:
- Macro: RF_CLIENT_PERF_EN.
- Defined:
  - PERF_RES_STALL increments each cycle in RES with go=0.
  - PERF_WAIT_STALL increments each cycle in WAIT without both operands captured.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is present.

Test Plan:
- Reset, then rs1=3, rs2=4, wen=1, rd=5, with RF data r3=0x11, r4=0x22 and no conflicts -> RRESE_1/2 and ALLOC_E assert in the same cycle; OP_VALID on cycle 3 with OP_A=0x11, OP_B=0x22, OP_WNAME=0; FE_1/FE_2 pulse once.
- Hold RRES_READY_2=0 for 4 cycles -> no enables asserted during the stall; reservation occurs on cycle 5; PERF_RES_STALL=4 (with _EN).
- Operand A valid 2 cycles before B -> A captured once and holds its value; free occurs in B's valid cycle; OP_A unchanged under later RF_D_OUT_1 changes.
- Allocate names 0 and 1, writeback name 1 then name 0 -> no WFE until name 0 is written; then W_F=0 and W_F=1 on consecutive F_READY cycles.
- Fill the queue with 4 outstanding writes, then a 5th wen request -> stays in RES until one free pops; head wraps from 3 to 0.
- WB_VALID with WB_NAME=2 when not outstanding -> RF_WE_1=0, WB_ERR=1 until RST.
